// File: rtl/cf_fifo_rr_sched_if.sv
// Requester/consumer bundle for the round-robin scheduler.
// Each requester's data sits in its own N-bit slice of req_data.
interface cf_fifo_rr_sched_if #(
  parameter int N     = 32,
  parameter int NREQ  = 4,
  parameter int DEPTH = 4
);
  localparam int SW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [NREQ-1:0]   req_valid;
  logic [NREQ*N-1:0] req_data;
  logic [NREQ-1:0]   req_last;
  logic [NREQ-1:0]   req_ready;
  logic              out_valid;
  logic [N-1:0]      out_data;
  logic [SW-1:0]     out_src;
  logic              out_last;
  logic              out_ready;
  logic [CW-1:0]     count;

  modport master (
    output req_valid, req_data, req_last, out_ready,
    input  req_ready, out_valid, out_data, out_src, out_last, count
  );

  modport slave (
    input  req_valid, req_data, req_last, out_ready,
    output req_ready, out_valid, out_data, out_src, out_last, count
  );
endinterface

// File: rtl/cf_fifo_rr_sched.sv
// Round-robin scheduler with packet locking that feeds one registered FIFO.
// Beats are tagged with their source; no enq/deq bypass in either direction.
module cf_fifo_rr_sched #(
  parameter int N         = 32,
  parameter int NREQ      = 4,
  parameter int DEPTH     = 4,
  parameter int MAX_BURST = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  cf_fifo_rr_sched_if.slave bus
);
  localparam int SW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);
  localparam int BW = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, LOCK} state_e;

  state_e        state_q, state_d;
  logic [SW-1:0] rr_ptr_q, rr_ptr_d;
  logic [SW-1:0] owner_q, owner_d;
  logic [BW-1:0] beat_cnt_q, beat_cnt_d;
  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic [N-1:0]  data_q [DEPTH];
  logic [SW-1:0] src_q  [DEPTH];
  logic          last_q [DEPTH];

  logic            space;
  logic            sel_found;
  logic [SW-1:0]   sel_idx;
  logic [SW-1:0]   grant_idx;
  logic [NREQ-1:0] ready;
  logic            enq;
  logic            deq;
  logic            release_grant;
  logic [BW-1:0]   beat_inc;

  // Space comes from the registered count only, so out_ready never reaches req_ready.
  assign space = (count_q < CW'(DEPTH));

  always_comb begin
    int idx;
    idx       = 0;
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr_q) + k) % NREQ;
      if (bus.req_valid[idx]) begin
        sel_found = 1'b1;
        sel_idx   = SW'(idx);
      end
    end
  end

  always_comb begin
    grant_idx = (state_q == LOCK) ? owner_q : sel_idx;
    ready     = '0;
    if (!rst_i && (state_q == LOCK || sel_found)) begin
      ready[grant_idx] = space;
    end
  end

  assign bus.req_ready = ready;
  assign enq           = |(ready & bus.req_valid);
  assign deq           = bus.out_valid && bus.out_ready;
  assign beat_inc      = beat_cnt_q + BW'(1);
  assign release_grant = bus.req_last[grant_idx] || (beat_inc == BW'(MAX_BURST));

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    beat_cnt_d = beat_cnt_q;
    if (enq) begin
      if (release_grant) begin
        state_d    = IDLE;
        rr_ptr_d   = (grant_idx == SW'(NREQ - 1)) ? '0 : grant_idx + SW'(1);
        beat_cnt_d = '0;
      end else if (state_q == IDLE) begin
        state_d    = LOCK;
        owner_d    = grant_idx;
        beat_cnt_d = BW'(1);
      end else begin
        beat_cnt_d = beat_inc;
      end
    end
  end

  always_comb begin
    head_d  = deq ? head_q + AW'(1) : head_q;
    tail_d  = enq ? tail_q + AW'(1) : tail_q;
    count_d = count_q;
    unique case ({enq, deq})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      beat_cnt_q <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      beat_cnt_q <= beat_cnt_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
    end
  end

  // Storage needs no reset: the empty-state output values mask stale entries.
  always_ff @(posedge clk_i) begin
    if (enq) begin
      data_q[tail_q] <= bus.req_data[grant_idx*N +: N];
      src_q[tail_q]  <= grant_idx;
      last_q[tail_q] <= bus.req_last[grant_idx];
    end
  end

  assign bus.out_valid = (count_q != '0);
  assign bus.out_data  = bus.out_valid ? data_q[head_q] : '1;
  assign bus.out_src   = bus.out_valid ? src_q[head_q]  : '0;
  assign bus.out_last  = bus.out_valid ? last_q[head_q] : 1'b0;
  assign bus.count     = count_q;
endmodule

// File: doc/cf_fifo_rr_sched.md
# cf_fifo_rr_sched

- Round-robin scheduler that shares one conflict-free output queue among NREQ requester channels.
- Each accepted beat is tagged with its source index.
- Supports packet locking: a multi-beat packet holds the grant until its last beat, bounded by MAX_BURST.
- Sits between several producer stages and a single consumer that expects CFFifo-style semantics: registered state, enq and deq independent, no bypass.

## Interface
Parameters:
- N, 32: data width.
- NREQ, 4: requester count, ≥2.
- DEPTH, 4: output queue entries, power of 2, ≥2.
- MAX_BURST, 4: maximum beats per lock, ≥1.
- SW = clog2(NREQ); CW = clog2(DEPTH+1).

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  per-requester beat valid.
- req_data  in  NREQ*N  beat data; requester i occupies bits [i*N +: N].
- req_last  in  NREQ  beat is last of packet.
- req_ready  out  NREQ  per-requester accept; at most one bit high.
- out_valid  out  1  queue non-empty.
- out_data  out  N  head data; all ones when empty.
- out_src  out  SW  head source index; 0 when empty.
- out_last  out  1  head last flag; 0 when empty.
- out_ready  in  1  consumer dequeue.
- count  out  CW  entries held.

## Operation
- **Queue**
  - Circular buffer of DEPTH entries {data, src, last} with head, tail and count registers.
  - space = (count < DEPTH), using registered count only. A dequeue in the same cycle does not create space.
  - deq = out_valid && out_ready. enq = any req_ready bit && the matching req_valid bit.
  - Simultaneous enq and deq: count unchanged, both pointers advance modulo DEPTH.
- **Arbiter state**
  - Registers: state (IDLE/LOCK), rr_ptr (SW bits), owner (SW bits), beat_cnt (counts 1..MAX_BURST).
  - IDLE: sel = the first i with req_valid[i], scanning rr_ptr, rr_ptr+1, … and wrapping mod NREQ. req_ready[sel] = space; all other ready bits are 0. No valid request means all ready bits are 0.
  - LOCK: req_ready[owner] = space; all others 0. Ready does not depend on req_valid[owner]. An owner that drops valid keeps the lock.
- **Transitions on an accepted beat from requester g**
  - Release condition: req_last[g] = 1, or (beat_cnt+1) = MAX_BURST. When MAX_BURST = 1, every beat releases.
  - On release: state goes to / stays IDLE; rr_ptr <= (g+1) mod NREQ; beat_cnt <= 0.
  - IDLE without release: state <= LOCK, owner <= g, beat_cnt <= 1.
  - LOCK without release: beat_cnt increments.
  - Forced release does not alter the stored last flag; out_last always equals req_last of that beat.
- **No-change cases**
  - No beat accepted: rr_ptr and state unchanged.
  - rr_ptr moves only on release.

## Timing
- Reset values: count 0, head/tail 0, state IDLE, rr_ptr 0, beat_cnt 0, out_valid 0, out_data all ones, out_src 0, out_last 0, req_ready all 0.
- req_ready is forced to 0 during any cycle with rst high.
- req_ready is combinational from req_valid, state and count. There is no combinational path from out_ready to req_ready.
- Latency: a beat accepted in cycle t is visible on out_* in cycle t+1. There is no same-cycle bypass.
- Throughput: 1 beat/cycle sustained when out_ready stays high, since count stays < DEPTH.
- Full (count = DEPTH): all req_ready bits are 0 even if out_ready = 1. Enqueue resumes the next cycle.
- Empty: out_valid = 0; out_ready is ignored; out_* hold their empty values.
- Reset mid-packet: the lock and all queue contents are discarded. The first cycle after reset behaves as IDLE with rr_ptr 0.

## Test plan
- **Reset, then round-robin rotation.** Reset; all 4 requesters valid, last=1, data 0xA0+i, out_ready=1.
  - Accepted order 0,1,2,3,0.
  - out_* one cycle later: 0xA0/src0, then 0xA1/src1, and so on.
- **Locked packet.** Requester 2 sends 3 beats (last on beat 3) while requester 1 is valid.
  - req_ready[1] = 0 throughout the 3 beats.
  - After release rr_ptr = 3, so requester 1 is next only if requester 3 is idle.
- **Owner stall.** Requester 0 sends beat 1 (last=0), then drops valid for 2 cycles while requester 3 is valid.
  - No beats are accepted during those 2 cycles.
  - Beat 2 of requester 0 is then accepted.
- **Burst cap.** MAX_BURST=4; requester 1 sends 6 beats, all with last=0.
  - The grant releases after beat 4; that beat is stored with out_last=0.
  - The next grant goes to another valid requester.
- **Full queue.** out_ready=0; 4 beats accepted → count=4, all req_ready=0.
  - Assert out_ready with a request pending: in that cycle req_ready stays 0 and count goes to 3.
  - The next cycle the request is accepted.
- **Reset mid-packet.** Assert rst after beat 2 of a locked packet from requester 3.
  - Next cycle: count=0, out_valid=0, out_data=0xFFFFFFFF.
  - A valid request from requester 1 alone is granted.
